// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_FF = 8'hFF;
  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_FE = 8'hFE;

  // Housekeeping bytes (overrun, BAT pass, ACK, resend) that never reach the display.
  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    case (b)
      IGN_00, IGN_FF, IGN_AA, IGN_FA, IGN_FE: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

endpackage

// File: rtl/scan_code_sequencer_prefix_timer.sv
// Idle-cycle watchdog for a partially received prefix sequence.
module prefix_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_r;

  // Held at zero outside a prefix; every byte restarts the idle window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (!run || restart || expired) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + W'(1);
    end
  end

  assign expired = run && (count_r == LAST);

endmodule

// File: rtl/scan_code_sequencer.sv
// Decodes PS/2 make/break/E0 byte sequences into push/pop/clear display commands.
module scan_code_sequencer
  import kbd_pkg::*;
#(
  parameter logic [7:0] BKSP_CODE      = 8'h66,
  parameter logic [7:0] ESC_CODE       = 8'h76,
  parameter int         REPEAT_FILTER  = 1,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       push_valid,
  output logic [7:0] push_code,
  output logic       push_ext,
  output logic       pop,
  output logic       clear,
  output logic       key_held,
  output logic [3:0] err_count
);

  state_t     state_r;
  logic [7:0] held_code_r;
  logic       held_ext_r;
  logic       expired_s;
  logic       make_s, brk_s, ext_s, err_s, match_s, accept_s, is_prefix_s;

  prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_r != ST_IDLE),
    .restart (byte_valid),
    .expired (expired_s)
  );

  // Classify the current byte (or idle timeout) as make, break or protocol error.
  always_comb begin
    make_s      = 1'b0;
    brk_s       = 1'b0;
    ext_s       = 1'b0;
    err_s       = 1'b0;
    is_prefix_s = (byte_in == PREFIX_EXT) || (byte_in == PREFIX_BRK);
    if (byte_valid) begin
      case (state_r)
        ST_IDLE: make_s = !is_prefix_s && !is_ignored(byte_in);
        ST_EXT: begin
          ext_s  = 1'b1;
          err_s  = (byte_in == PREFIX_EXT);
          make_s = !is_prefix_s;
        end
        ST_BRK, ST_EXT_BRK: begin
          ext_s = (state_r == ST_EXT_BRK);
          err_s = is_prefix_s;
          brk_s = !is_prefix_s;
        end
        default: make_s = 1'b0;
      endcase
    end else begin
      err_s = expired_s;
    end
    match_s  = key_held && (held_ext_r == ext_s) && (held_code_r == byte_in);
    accept_s = make_s && !((REPEAT_FILTER != 0) && match_s);
  end

  // Prefix FSM, held-key tracking and registered command strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      push_valid  <= 1'b0;
      push_code   <= 8'h00;
      push_ext    <= 1'b0;
      pop         <= 1'b0;
      clear       <= 1'b0;
      key_held    <= 1'b0;
      held_code_r <= 8'h00;
      held_ext_r  <= 1'b0;
      err_count   <= 4'd0;
    end else begin
      push_valid <= 1'b0;
      pop        <= 1'b0;
      clear      <= 1'b0;

      if (byte_valid) begin
        case (state_r)
          ST_IDLE:
            if (byte_in == PREFIX_EXT)      state_r <= ST_EXT;
            else if (byte_in == PREFIX_BRK) state_r <= ST_BRK;
            else                            state_r <= ST_IDLE;
          ST_EXT:
            if (byte_in == PREFIX_BRK)      state_r <= ST_EXT_BRK;
            else if (byte_in == PREFIX_EXT) state_r <= ST_EXT;
            else                            state_r <= ST_IDLE;
          default: state_r <= ST_IDLE;
        endcase
      end else if (expired_s) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_r;
      end

      if (err_s) err_count <= sat_inc(err_count);

      if (accept_s) begin
        key_held    <= 1'b1;
        held_code_r <= byte_in;
        held_ext_r  <= ext_s;
        if (!ext_s && byte_in == ESC_CODE) begin
          clear <= 1'b1;
        end else if (!ext_s && byte_in == BKSP_CODE) begin
          pop <= 1'b1;
        end else begin
          push_valid <= 1'b1;
          push_code  <= byte_in;
          push_ext   <= ext_s;
        end
      end else if (brk_s && match_s) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_code_sequencer.sv
// Randomised and directed bench for scan_code_sequencer against a flag-based protocol model.
module tb_scan_code_sequencer;

  localparam int T  = 8;
  localparam int RF = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       push_valid, push_ext, pop, clear, key_held;
  logic [7:0] push_code;
  logic [3:0] err_count;

  scan_code_sequencer #(.REPEAT_FILTER(RF), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
    .push_valid(push_valid), .push_code(push_code), .push_ext(push_ext),
    .pop(pop), .clear(clear), .key_held(key_held), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] e, o;

  // Model state: "E0 seen", "F0 seen", held key, error total, idle cycles in a prefix.
  bit       m_e0, m_f0, m_held;
  logic [8:0] m_pair;
  int       m_err, m_idle;

  function automatic logic [31:0] ev(input int c, input logic [2:0] k, input logic x, input logic [7:0] code);
    return {c[19:0], k, x, code};
  endfunction

  task automatic model_reset();
    m_e0 = 0; m_f0 = 0; m_held = 0; m_pair = 9'd0; m_err = 0; m_idle = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic model_err();
    if (m_err < 15) m_err = m_err + 1;
  endtask

  task automatic model_make(input bit x, input logic [7:0] c);
    if (RF != 0 && m_held && m_pair == {x, c}) return;
    m_held = 1; m_pair = {x, c};
    if (!x && c == 8'h76)      exp_q.push_back(ev(cyc + 1, 3'b001, 1'b0, 8'h00));
    else if (!x && c == 8'h66) exp_q.push_back(ev(cyc + 1, 3'b010, 1'b0, 8'h00));
    else                       exp_q.push_back(ev(cyc + 1, 3'b100, x, c));
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_idle = 0;
    if (b == 8'hE0) begin
      if (m_f0) begin model_err(); m_e0 = 0; m_f0 = 0; end
      else if (m_e0) model_err();
      else m_e0 = 1;
    end else if (b == 8'hF0) begin
      if (m_f0) begin model_err(); m_e0 = 0; m_f0 = 0; end
      else m_f0 = 1;
    end else if (m_f0) begin
      if (m_held && m_pair == {m_e0, b}) m_held = 0;
      m_e0 = 0; m_f0 = 0;
    end else if (m_e0) begin
      model_make(1'b1, b); m_e0 = 0;
    end else if (!(b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE})) begin
      model_make(1'b0, b);
    end
  endtask

  // One clock: update model, drive DUT, record any strobe seen after the edge.
  task automatic step(input bit v, input logic [7:0] b);
    if (v) model_byte(b);
    else if (m_e0 || m_f0) begin
      m_idle = m_idle + 1;
      if (m_idle == T) begin model_err(); m_e0 = 0; m_f0 = 0; m_idle = 0; end
    end
    byte_valid = v; byte_in = b;
    @(posedge clk); #1;
    cyc = cyc + 1;
    byte_valid = 1'b0;
    if (push_valid || pop || clear)
      obs_q.push_back(ev(cyc, {push_valid, pop, clear}, push_valid ? push_ext : 1'b0,
                         push_valid ? push_code : 8'h00));
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    cyc = cyc + 2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({push_valid, pop, clear, push_ext, push_code, key_held, err_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {push_valid, pop, clear, push_ext, push_code, key_held, err_count});
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_push_break();
    step(1, 8'h1C); step(1, 8'hF0); step(1, 8'h1C); step(1, 8'h32); step(0, 8'h00);
    n_tests++;
    if (obs_q.size() !== 2) begin n_fail++; $display("FAIL push_break_count: got %0d expected 2", obs_q.size()); end
    n_tests++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL push_break_held: got %b expected 1", key_held); end
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL push_break_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_repeat();
    step(1, 8'h1C); step(1, 8'h1C); step(1, 8'h1C); step(1, 8'hF0); step(1, 8'h1C); step(0, 8'h00);
    n_tests++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL repeat_release: got %b expected 0", key_held); end
    step(1, 8'h1C); step(0, 8'h00);
    n_tests++;
    if (obs_q.size() !== 2 || key_held !== 1'b1) begin
      n_fail++; $display("FAIL repeat_count: got %0d/%b expected 2/1", obs_q.size(), key_held);
    end
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL repeat_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_ext_pop_clear();
    step(1, 8'hE0); step(1, 8'h75); step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75); step(0, 8'h00);
    n_tests++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL ext_release: got %b expected 0", key_held); end
    step(1, 8'h66); step(0, 8'h00); step(1, 8'h76); step(0, 8'h00);
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL ext_pop_clear_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_errors();
    step(1, 8'hF0); step(1, 8'hF0); step(0, 8'h00);
    n_tests++;
    if (err_count !== 4'd1) begin n_fail++; $display("FAIL err_first: got %0d expected 1", err_count); end
    step(1, 8'h1C); step(1, 8'hE0); step(1, 8'hE0); step(1, 8'h75);
    step(1, 8'hF0); step(1, 8'hE0); step(1, 8'h32); step(0, 8'h00);
    n_tests++;
    if (err_count !== 4'd3) begin n_fail++; $display("FAIL err_mixed: got %0d expected 3", err_count); end
    repeat (17) begin step(1, 8'hF0); step(1, 8'hF0); end
    step(0, 8'h00);
    n_tests++;
    if (err_count !== 4'd15) begin n_fail++; $display("FAIL err_saturate: got %0d expected 15", err_count); end
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL errors_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 8'hE0);
    repeat (T) step(0, 8'h00);
    n_tests++;
    if (err_count !== 4'd1) begin n_fail++; $display("FAIL timeout_err: got %0d expected 1", err_count); end
    step(1, 8'h1C); step(0, 8'h00);
    // Byte arriving on the expiry cycle is decoded instead of timing out.
    step(1, 8'hE0);
    repeat (T - 1) step(0, 8'h00);
    step(1, 8'h75); step(0, 8'h00);
    n_tests++;
    if (err_count !== 4'd1) begin n_fail++; $display("FAIL timeout_byte_wins: got %0d expected 1", err_count); end
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL timeout_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_prefix();
    step(1, 8'h1C); step(1, 8'hF0); step(1, 8'hF0); step(1, 8'hE0);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({push_valid, key_held, err_count} !== 6'd0) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", {push_valid, key_held, err_count});
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    cyc = cyc + 2;
    reset = 1'b1;
    step(1, 8'h75); step(1, 8'hF0); step(1, 8'h1C); step(0, 8'h00);
    n_tests++;
    if (err_count !== 4'd0 || key_held !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_state: got %0d/%b expected 0/1", err_count, key_held);
    end
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [12] = '{8'h1C, 8'h32, 8'hF0, 8'h32, 8'h66, 8'hE0, 8'h75,
                             8'hE0, 8'hF0, 8'h75, 8'h76, 8'h4D};
    foreach (seq[i]) step(1, seq[i]);
    step(0, 8'h00);
    while (exp_q.size() + obs_q.size() > 0) begin
      n_tests++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back_event: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [11] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h66, 8'h76, 8'h75,
                              8'h00, 8'hAA, 8'hFE, 8'h1C};
    int r;
    repeat (4) begin
      do_reset();
      repeat (150) begin
        r = int'($urandom_range(0, 19));
        if (r == 0) repeat ($urandom_range(5, 10)) step(0, 8'h00);
        else if (r < 4) step(0, 8'h00);
        else if (r == 4) step(1, 8'($urandom_range(0, 255)));
        else step(1, pool[$urandom_range(0, 10)]);
        n_tests++;
        if (key_held !== m_held || err_count !== 4'(m_err)) begin
          n_fail++;
          $display("FAIL random_state: got held=%b err=%0d expected held=%b err=%0d",
                   key_held, err_count, m_held, m_err);
        end
      end
      step(0, 8'h00);
      while (exp_q.size() + obs_q.size() > 0) begin
        n_tests++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
        if (o !== e) begin n_fail++; $display("FAIL random_event: got %h expected %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_break();
    test_repeat();
    test_ext_pop_clear();
    test_errors();
    test_timeout();
    test_reset_mid_prefix();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
